// File: rtl/branch_predictor.sv
// branch_predictor: 2-bit saturating-counter branch direction predictor.
// Looks up the counter table in IF, carries the prediction into ID, flags
// mispredictions when the ID comparator resolves a branch, trains the table
// and keeps saturating branch/mispredict statistics.
//
// Ports:
//   clk, rst_n        pipeline clock, asynchronous active-low reset
//   fetch_pc          IF-stage program counter
//   fetch_is_branch   IF predecode: fetched instruction is a conditional branch
//   stall, flush      IF/ID prediction register control (flush has priority)
//   resolve_valid     ID stage resolves a conditional branch this cycle
//   resolve_pc        PC of the resolving branch
//   resolve_taken     resolved branch direction
//   predict_taken     combinational IF prediction
//   pred_taken_id     registered prediction of the instruction in ID
//   mispredict        combinational misprediction flag (valid with resolve_valid)
//   branch_count      resolved conditional branches, saturating
//   mispredict_count  mispredictions, saturating
module branch_predictor #(
    parameter int unsigned INDEX_BITS = 4,
    parameter int unsigned PC_WIDTH   = 16
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [PC_WIDTH-1:0] fetch_pc,
    input  logic                fetch_is_branch,
    input  logic                stall,
    input  logic                flush,
    input  logic                resolve_valid,
    input  logic [PC_WIDTH-1:0] resolve_pc,
    input  logic                resolve_taken,
    output logic                predict_taken,
    output logic                pred_taken_id,
    output logic                mispredict,
    output logic [15:0]         branch_count,
    output logic [15:0]         mispredict_count
);

    localparam int unsigned ENTRIES = 2 ** INDEX_BITS;
    localparam int unsigned STAT_W  = 16;

    logic [1:0]            table_q [ENTRIES];
    logic [INDEX_BITS-1:0] fetch_idx;
    logic [INDEX_BITS-1:0] resolve_idx;
    logic [1:0]            ctr_cur;
    logic [1:0]            ctr_next;
    logic                  unused_pc_bits;

    // Halfword-aligned instructions: bit 0 carries no index information.
    assign fetch_idx   = fetch_pc[INDEX_BITS:1];
    assign resolve_idx = resolve_pc[INDEX_BITS:1];

    assign unused_pc_bits = ^{fetch_pc[PC_WIDTH-1:INDEX_BITS+1], fetch_pc[0],
                              resolve_pc[PC_WIDTH-1:INDEX_BITS+1], resolve_pc[0]};

    // IF prediction reads the pre-update counter; no write bypass.
    assign predict_taken = fetch_is_branch & table_q[fetch_idx][1];

    assign mispredict = resolve_valid & (resolve_taken != pred_taken_id);

    // Saturating counter update for the resolving entry.
    always_comb begin
        ctr_cur  = table_q[resolve_idx];
        ctr_next = ctr_cur;
        if (resolve_taken) begin
            if (ctr_cur != 2'b11) begin
                ctr_next = ctr_cur + 2'd1;
            end
        end else begin
            if (ctr_cur != 2'b00) begin
                ctr_next = ctr_cur - 2'd1;
            end
        end
    end

    // Counter table: reset to weak not-taken, trained only by resolve_valid.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < ENTRIES; i++) begin
                table_q[i] <= 2'b01;
            end
        end else if (resolve_valid) begin
            table_q[resolve_idx] <= ctr_next;
        end
    end

    // IF/ID prediction register: flush beats stall.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pred_taken_id <= 1'b0;
        end else if (flush) begin
            pred_taken_id <= 1'b0;
        end else if (!stall) begin
            pred_taken_id <= predict_taken;
        end
    end

    // Statistics counters, saturating at all-ones.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_count     <= '0;
            mispredict_count <= '0;
        end else begin
            if (resolve_valid && (branch_count != '1)) begin
                branch_count <= branch_count + STAT_W'(1);
            end
            if (mispredict && (mispredict_count != '1)) begin
                mispredict_count <= mispredict_count + STAT_W'(1);
            end
        end
    end

endmodule

// File: doc/branch_predictor.md
# branch_predictor

Dynamic branch direction predictor for the 5-stage pipeline. In IF it looks up a table of 2-bit saturating counters indexed by the fetch PC and predicts taken/not-taken for conditional branches. It carries that prediction alongside the instruction into ID. When the ID-stage branch comparator resolves the branch, the predictor flags a misprediction and trains the table. It also keeps saturating branch and mispredict statistics counters.

## Interface
Parameters:
- INDEX_BITS, 4, table index width; table holds 2^INDEX_BITS entries.
- PC_WIDTH, 16, program counter width.

Ports:
- Clock  in  1  single pipeline clock; all state updates on its rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- FetchPC  in  PC_WIDTH  IF-stage program counter.
- FetchIsBranch  in  1  IF predecode: the fetched instruction is a conditional branch (BLT/BGT/BEQ).
- Stall  in  1  pipeline stall; holds the IF/ID prediction register.
- Flush  in  1  IF/ID flush; clears the IF/ID prediction register.
- ResolveValid  in  1  ID stage holds a conditional branch whose outcome is resolved this cycle.
- ResolvePC  in  PC_WIDTH  PC of the resolving branch.
- ResolveTaken  in  1  resolved direction of the branch (comparator result with Jump excluded).
- PredictTaken  out  1  combinational IF prediction.
- PredTakenID  out  1  registered prediction of the instruction currently in ID.
- Mispredict  out  1  combinational; ResolveValid & (ResolveTaken != PredTakenID).
- BranchCount  out  16  resolved conditional branches, saturating.
- MispredictCount  out  16  mispredictions, saturating.

## Operation
- Table: 2^INDEX_BITS entries of 2-bit counters. Encoding: 00 strong NT, 01 weak NT, 10 weak T, 11 strong T.
- Index = PC[INDEX_BITS:1]. Bit 0 is ignored because instructions are 16-bit halfword-aligned.
- PredictTaken = FetchIsBranch & counter[index(FetchPC)][1]. It is 0 whenever FetchIsBranch = 0.
- IF/ID prediction register (PredTakenID), updated on each rising edge in priority order:
  - Flush: load 0.
  - else Stall: hold the current value.
  - else: load PredictTaken.
- Training: when ResolveValid = 1, the entry at index(ResolvePC) is updated.
  - ResolveTaken = 1: increment, saturating at 11.
  - ResolveTaken = 0: decrement, saturating at 00.
  - Training is not gated by Stall or Flush. ResolveValid is the sole qualifier.
- Statistics:
  - BranchCount increments on each ResolveValid cycle.
  - MispredictCount increments on each cycle with Mispredict = 1.
  - Both counters saturate at 16'hFFFF and do not wrap.
- Jumps are never predicted or trained. The comparator's Jump path handles them.
- Consumer: the pipeline control uses Mispredict to flush IF/ID and to select the redirect PC (branch target if ResolveTaken, else PC+2).

## Timing
- Reset (asynchronous, Reset_n = 0):
  - Every table entry = 01 (weak NT).
  - PredTakenID = 0, BranchCount = 0, MispredictCount = 0.
  - PredictTaken and Mispredict are therefore 0.
  - Releasing reset mid-operation restarts cleanly from these values; no pending update survives.
- PredictTaken: zero-cycle latency, combinational from FetchPC and the table.
- Table update latency: the entry changes on the edge ending a ResolveValid cycle and is visible to PredictTaken in the following cycle.
- Same-index read/write in one cycle: PredictTaken uses the pre-update (old) counter value; no bypass.
- Mispredict: combinational in the resolve cycle, using the PredTakenID captured one edge earlier. It is valid only while ResolveValid = 1.
- Stall and ResolveValid both high: training and stats still update once per ResolveValid cycle. The ID stage must deassert ResolveValid while it is stalled, so one branch is counted once.
- Simultaneous Flush and Stall: Flush wins and PredTakenID becomes 0.
- Saturation boundaries:
  - Counter at 11 with ResolveTaken = 1 stays 11.
  - Counter at 00 with ResolveTaken = 0 stays 00.
  - Stats counters at FFFF stay FFFF.

## Test plan
- Reset then fetch: Reset_n low, then release; FetchPC = 16'h0010, FetchIsBranch = 1 → PredictTaken = 0, PredTakenID = 0 next cycle, both stats counters = 0.
- Training to taken:
  - Resolve PC 16'h0010 taken → entry goes 01→10; PredictTaken at FetchPC 16'h0010 = 1 on the following cycle.
  - Two more taken resolves → entry stays 11.
- Mispredict flag:
  - PredTakenID = 1, ResolveValid = 1, ResolveTaken = 0 → Mispredict = 1, MispredictCount +1.
  - ResolveTaken = 1 instead → Mispredict = 0.
- Pipeline control:
  - Stall high for 3 cycles while FetchPC alternates predictions → PredTakenID holds its value.
  - Flush & Stall together → PredTakenID = 0.
- Aliasing and same-cycle read/write:
  - Resolve 16'h0022 taken while fetching 16'h0002 (same index for INDEX_BITS = 4) → this cycle's PredictTaken reflects the old value; next cycle it reflects the new value.
- Saturation: force 65537 resolves (test-only fast path, or BranchCount preloaded near the limit) → BranchCount = 16'hFFFF, no wrap to 0.
